pc_redirect_controller: RTL

Sequences the fetch program counter from the EX-stage outcome of `branch_decision_unit`. Owns the PC register, steers it to PC+4, the branch/jump target, or the trap vector, and issues the IF/ID and ID/EX flushes on every redirect. Raises a trap on misaligned targets and keeps saturating branch statistics counters. Sits between the fetch stage and the EX-stage branch logic, under control of the hazard unit's stall.

---
 rtl/package_project_typedefs.sv | 32 +++
 rtl/sat_counter.sv | 23 ++
 rtl/pc_redirect_controller.sv | 107 ++++++++++
 3 files changed

// File: rtl/package_project_typedefs.sv
// Shared fetch/branch typedefs: branch classes, redirect FSM states and
// the default trap vector.
package package_project_typedefs;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

  typedef enum logic [3:0] {
    NO_JUMP_BRANCH,
    BRANCH_EQ,
    BRANCH_NE,
    BRANCH_LT,
    BRANCH_GE,
    BRANCH_LTU,
    BRANCH_GEU,
    JUMP_AL,
    JUMP_ALR
  } BranchControl;

  typedef enum logic [1:0] {
    RUN,
    REDIRECT,
    TRAP
  } RedirectState;

  // JALR drops bit 0 of its computed target; every other class uses it as is
  function automatic logic [PC_W-1:0] effective_target(input BranchControl bt,
                                                       input logic [PC_W-1:0] tgt);
    return (bt == JUMP_ALR) ? {tgt[PC_W-1:1], 1'b0} : tgt;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pc_redirect_controller.sv
// Fetch PC sequencer: steps PC+4, redirects on taken EX branches/jumps,
// traps misaligned targets, and keeps branch statistics.
module pc_redirect_controller
  import package_project_typedefs::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [PC_W-1:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT,
  parameter int unsigned     CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  BranchControl      branch_type,
  input  logic              branch_decision,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   pc,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              trap,
  output logic [PC_W-1:0]   trap_pc,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  taken_count
);

  RedirectState    r_state;
  RedirectState    w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic            r_trap;
  logic [PC_W-1:0] r_trap_pc;
  logic [PC_W-1:0] w_eff_target;
  logic            w_misaligned;
  logic            w_evaluate;
  logic            w_redirect;
  logic            w_trap_take;

  assign w_eff_target = effective_target(branch_type, branch_target);
  assign w_misaligned = (w_eff_target[1:0] != 2'b00);
  assign w_evaluate   = (r_state == RUN) && ex_valid && !stall &&
                        (branch_type != NO_JUMP_BRANCH);

  // Next state / next PC; the post-redirect states only step past the bubble
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_redirect   = 1'b0;
    w_trap_take  = 1'b0;
    if (!stall) begin
      w_next_pc = r_pc + 32'd4;
      unique case (r_state)
        RUN: begin
          if (w_evaluate && branch_decision) begin
            if (w_misaligned) begin
              w_trap_take  = 1'b1;
              w_next_pc    = TRAP_VECTOR;
              w_next_state = TRAP;
            end else begin
              w_redirect   = 1'b1;
              w_next_pc    = w_eff_target;
              w_next_state = REDIRECT;
            end
          end
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_pc      <= RESET_PC;
      r_trap    <= 1'b0;
      r_trap_pc <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_trap  <= w_trap_take;
      if (w_trap_take) begin
        r_trap_pc <= ex_pc;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (w_evaluate),
    .count (branch_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (w_redirect | w_trap_take),
    .count (taken_count)
  );

  assign pc          = r_pc;
  assign trap        = r_trap;
  assign trap_pc     = r_trap_pc;
  assign flush_if_id = (w_redirect | w_trap_take) & ~reset;
  assign flush_id_ex = (w_redirect | w_trap_take) & ~reset;

endmodule
